// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter
//   Merges two sram-like masters (m0 = instruction side, m1 = data side) onto
//   one in-order memory bridge.
//   - m1 normally wins arbitration. m0 is forced through after STARVE_MAX
//     consecutive m1 grants while m0 is waiting.
//   - If a presented request is not accepted, the grant is locked to that
//     master until the bridge accepts it.
//   - A DEPTH-entry order FIFO records which master owns each outstanding
//     transaction. In-order responses are then routed back to that master.
// Ports
//   clk, resetn             : clock, asynchronous active-low reset
//   m0_req/m0_cmd           : m0 request and {wr,size,wstrb,addr,wdata}
//   m0_addr_ok/m0_data_ok   : m0 accept / response strobes
//   m1_*                    : same for m1
//   bus_req/bus_cmd         : merged request towards the bridge (combinational)
//   bus_addr_ok/bus_data_ok : bridge accept / in-order response strobes
//   pend_cnt                : outstanding transaction count (0..DEPTH)
//   err                     : sticky flag, response seen with nothing outstanding
module sram_req_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_req,
  input  logic [70:0] m0_cmd,
  output logic        m0_addr_ok,
  output logic        m0_data_ok,
  input  logic        m1_req,
  input  logic [70:0] m1_cmd,
  output logic        m1_addr_ok,
  output logic        m1_data_ok,
  output logic        bus_req,
  output logic [70:0] bus_cmd,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  output logic [3:0]  pend_cnt,
  output logic        err
);

  localparam int         PW       = $clog2(DEPTH);
  localparam logic [3:0] DEPTH_C  = 4'(DEPTH);
  localparam logic [3:0] STARVE_C = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t          state_r;
  logic [3:0]      cnt_r;
  logic [3:0]      starve_r;
  logic            err_r;
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic            id_r [DEPTH];

  logic            grant_s;
  logic            req_g_s;
  logic            push_s;
  logic            pop_s;
  logic            empty_s;
  logic            head_s;

  // Grant selection: locked states pin the grant, IDLE prefers m1 unless m0 is starved
  always_comb begin
    grant_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (m0_req && (starve_r == STARVE_C)) begin
          grant_s = 1'b0;
        end else if (m1_req) begin
          grant_s = 1'b1;
        end else begin
          grant_s = 1'b0;
        end
      end
      LOCK0:   grant_s = 1'b0;
      LOCK1:   grant_s = 1'b1;
      default: grant_s = 1'b0;
    endcase
  end

  // Bus request path and strobes. All are gated by resetn so nothing fires
  // while reset is held. Fullness uses the registered count only, so a pop
  // in the same cycle cannot let a push through.
  always_comb begin
    req_g_s    = grant_s ? m1_req : m0_req;
    empty_s    = (cnt_r == 4'd0);
    head_s     = id_r[rd_ptr_r];
    bus_req    = resetn & req_g_s & (cnt_r < DEPTH_C);
    bus_cmd    = resetn ? (grant_s ? m1_cmd : m0_cmd) : 71'd0;
    push_s     = bus_req & bus_addr_ok;
    pop_s      = resetn & bus_data_ok & ~empty_s;
    m0_addr_ok = push_s & ~grant_s;
    m1_addr_ok = push_s & grant_s;
    m0_data_ok = pop_s & ~head_s;
    m1_data_ok = pop_s & head_s;
  end

  assign pend_cnt = cnt_r;
  assign err      = err_r;

  // Lock FSM: remember a presented-but-unaccepted request until the bridge takes it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus_req && !bus_addr_ok) begin
            state_r <= grant_s ? LOCK1 : LOCK0;
          end else begin
            state_r <= IDLE;
          end
        end
        LOCK0, LOCK1: begin
          if (bus_addr_ok) begin
            state_r <= IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Order FIFO of master ids. Pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= 4'd0;
      for (int i = 0; i < DEPTH; i++) begin
        id_r[i] <= 1'b0;
      end
    end else begin
      if (push_s) begin
        id_r[wr_ptr_r] <= grant_s;
        wr_ptr_r       <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + 4'd1;
        2'b01:   cnt_r <= cnt_r - 4'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Starvation counter: consecutive m1 wins while m0 waits, saturating
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_r <= 4'd0;
    end else if (!m0_req || m0_addr_ok) begin
      starve_r <= 4'd0;
    end else if (m1_addr_ok && (starve_r < STARVE_C)) begin
      starve_r <= starve_r + 4'd1;
    end else begin
      starve_r <= starve_r;
    end
  end

  // Sticky error: a response arrived with nothing outstanding
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_r <= 1'b0;
    end else if (bus_data_ok && empty_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Testbench for sram_req_arbiter. Directed scenarios followed by random
// traffic. Everything is checked against a queue-based model of the
// arbitration rules.
module tb_sram_req_arbiter;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 4;

  logic        clk;
  logic        resetn;
  logic        m0_req, m1_req;
  logic [70:0] m0_cmd, m1_cmd;
  logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
  logic        bus_req;
  logic [70:0] bus_cmd;
  logic        bus_addr_ok, bus_data_ok;
  logic [3:0]  pend_cnt;
  logic        err;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  int q[$];         // master id of each outstanding transaction, oldest first
  int lock_m  = -1; // master whose request is waiting for acceptance, -1 if none
  int starve  = 0;
  bit err_m   = 1'b0;

  sram_req_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok),
    .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok),
    .bus_req(bus_req), .bus_cmd(bus_cmd),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .pend_cnt(pend_cnt), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [70:0] obs, input logic [70:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    lock_m = -1;
    starve = 0;
    err_m  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".bus_req"}, 71'(bus_req), 71'd0);
    check({tag, ".bus_cmd"}, bus_cmd, 71'd0);
    check({tag, ".m0_addr_ok"}, 71'(m0_addr_ok), 71'd0);
    check({tag, ".m1_addr_ok"}, 71'(m1_addr_ok), 71'd0);
    check({tag, ".m0_data_ok"}, 71'(m0_data_ok), 71'd0);
    check({tag, ".m1_data_ok"}, 71'(m1_data_ok), 71'd0);
    check({tag, ".pend_cnt"}, 71'(pend_cnt), 71'd0);
    check({tag, ".err"}, 71'(err), 71'd0);
  endtask

  // One clock cycle: drive, check outputs against the model, then advance the model.
  task automatic cycle(input bit r0, input bit r1, input bit aok, input bit dok);
    logic [70:0] c0, c1;
    int g, head;
    bit breq, acc, pop;
    @(negedge clk);
    c0 = 71'({$urandom, $urandom, $urandom});
    c1 = 71'({$urandom, $urandom, $urandom});
    m0_req = r0; m1_req = r1; m0_cmd = c0; m1_cmd = c1;
    bus_addr_ok = aok; bus_data_ok = dok;
    #1;
    if (lock_m >= 0) g = lock_m;
    else if (r0 && starve == STARVE_MAX) g = 0;
    else if (r1) g = 1;
    else g = 0;
    breq = ((g == 1) ? r1 : r0) && (q.size() < DEPTH);
    acc  = breq && aok;
    pop  = dok && (q.size() > 0);
    head = pop ? q[0] : -1;
    check("bus_req", 71'(bus_req), 71'(breq));
    check("bus_cmd", bus_cmd, (g == 1) ? c1 : c0);
    check("m0_addr_ok", 71'(m0_addr_ok), 71'(acc && g == 0));
    check("m1_addr_ok", 71'(m1_addr_ok), 71'(acc && g == 1));
    check("m0_data_ok", 71'(m0_data_ok), 71'(head == 0));
    check("m1_data_ok", 71'(m1_data_ok), 71'(head == 1));
    check("pend_cnt", 71'(pend_cnt), 71'(q.size()));
    check("err", 71'(err), 71'(err_m));
    @(posedge clk);
    if (dok && q.size() == 0) err_m = 1'b1;
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(g);
    if (lock_m < 0 && breq && !aok) lock_m = g;
    else if (lock_m >= 0 && aok) lock_m = -1;
    if (!r0 || (acc && g == 0)) starve = 0;
    else if (acc && g == 1 && starve < STARVE_MAX) starve++;
  endtask

  // Full reset pulse. Reqs can be held high to show outputs are still forced to 0.
  task automatic do_reset(input bit busy);
    @(negedge clk);
    m0_req = busy; m1_req = busy; bus_addr_ok = busy; bus_data_ok = busy;
    #2;
    resetn = 1'b0;
    #1;
    model_clear();
    check_reset_outputs("reset");
    m0_req = 1'b0; m1_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic drain();
    while (q.size() > 0) cycle(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    resetn = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0; m0_cmd = 71'd0; m1_cmd = 71'd0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    #1;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // response with nothing outstanding: ignored, err sticks
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    do_reset(1'b0);

    // starvation: m1 wins 4 times, then m0
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (7) cycle(1'b1, 1'b1, 1'b1, 1'b1);
    drain();

    // lock on m0 while bridge stalls, m1 arrives later
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    drain();

    // full FIFO blocks requests, including in the cycle of a pop
    while (q.size() < DEPTH) cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    drain();

    // responses routed in acceptance order
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // reset while two outstanding and locked on m1
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    do_reset(1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)));
      if (i == 300) do_reset(1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
